// File: rtl/core_sequencer.sv
// Fetch/execute sequencer for the accumulator core: owns pc, gates write strobes.
// Optional CORE_SEQUENCER_CYCLE_COUNT_EN adds a saturating busy-cycle counter.
module core_sequencer #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int              MEM_LAT  = 2
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            start,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            acc_write,
  input  logic            branch,
  input  logic            branch_if_zero,
  input  logic            zero,
  input  logic            done,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic            instr_latch,
  output logic            reg_we,
  output logic            acc_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            busy,
`ifdef CORE_SEQUENCER_CYCLE_COUNT_EN
  output logic            halted,
  output logic [31:0]     cycle_count
`else
  output logic            halted
`endif
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          taken;
  logic          launch;

  assign taken  = branch & (~branch_if_zero | zero);
  assign launch = start & ((state == S_IDLE) | (state == S_HALT));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= START_PC;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= START_PC;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          if (done) begin
            state <= S_HALT;
          end else if (mem_read) begin
            cnt   <= LAT_LOAD;
            state <= S_MEM_WAIT;
          end else begin
            pc    <= taken ? target : pc + PC_W'(1);
            state <= S_FETCH;
          end
        end
        S_MEM_WAIT: begin
          if (cnt == '0) begin
            pc    <= pc + PC_W'(1);
            state <= S_FETCH;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    instr_latch = 1'b0;
    reg_we      = 1'b0;
    acc_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    unique case (state)
      S_FETCH: begin
        instr_latch = 1'b1;
        busy        = 1'b1;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (!done) begin
          if (mem_read) begin
            mem_re = 1'b1;
          end else begin
            reg_we = reg_write;
            acc_we = acc_write;
            mem_we = mem_write;
          end
        end
      end
      S_MEM_WAIT: begin
        busy   = 1'b1;
        mem_re = 1'b1;
        acc_we = (cnt == '0);
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef CORE_SEQUENCER_CYCLE_COUNT_EN
  always_ff @(posedge CLK) begin
    if (Reset || launch) begin
      cycle_count <= '0;
    end else if (busy && cycle_count != 32'hFFFF_FFFF) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`else
  logic unused_launch;
  assign unused_launch = launch;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: program run, load, branches, wrap, reset.
// Cycle-count checks are active when CORE_SEQUENCER_CYCLE_COUNT_EN is defined.
module tb_core_sequencer;

  localparam int PC_W = 10;

  logic            CLK = 1'b0;
  logic            Reset = 1'b1;
  logic            start = 1'b0;
  logic            mem_read = 1'b0;
  logic            mem_write = 1'b0;
  logic            reg_write = 1'b0;
  logic            acc_write = 1'b0;
  logic            branch = 1'b0;
  logic            branch_if_zero = 1'b0;
  logic            zero = 1'b0;
  logic            done = 1'b0;
  logic [PC_W-1:0] target = '0;
  logic [PC_W-1:0] pc;
  logic            instr_latch, reg_we, acc_we;
  logic            mem_re, mem_we, busy, halted;
`ifdef CORE_SEQUENCER_CYCLE_COUNT_EN
  logic [31:0]     cycle_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  core_sequencer #(
    .PC_W    (PC_W),
    .START_PC('0),
    .MEM_LAT (2)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .start         (start),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .acc_write     (acc_write),
    .branch        (branch),
    .branch_if_zero(branch_if_zero),
    .zero          (zero),
    .done          (done),
    .target        (target),
    .pc            (pc),
    .instr_latch   (instr_latch),
    .reg_we        (reg_we),
    .acc_we        (acc_we),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .busy          (busy),
`ifdef CORE_SEQUENCER_CYCLE_COUNT_EN
    .halted        (halted),
    .cycle_count   (cycle_count)
`else
    .halted        (halted)
`endif
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    start          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    reg_write      = 1'b0;
    acc_write      = 1'b0;
    branch         = 1'b0;
    branch_if_zero = 1'b0;
    zero           = 1'b0;
    done           = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    cyc();
    cyc();
    #1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_strobes",
          32'({instr_latch, reg_we, acc_we, mem_re, mem_we}), 32'h0);

    Reset = 1'b0;
    cyc();
    start = 1'b1;
    #1;
    check("idle_busy", 32'(busy), 32'h0);

    cyc();
    #1;
    check("c1_latch", 32'(instr_latch), 32'h1);
    check("c1_pc", 32'(pc), 32'h0);
    check("c1_busy", 32'(busy), 32'h1);
    cyc();
    acc_write = 1'b1;
    #1;
    check("c2_acc_we", 32'(acc_we), 32'h1);
    check("c2_pc", 32'(pc), 32'h0);
    cyc();
    #1;
    check("c3_pc", 32'(pc), 32'h1);
    check("c3_acc_we", 32'(acc_we), 32'h0);
    cyc();
    acc_write = 1'b1;
    #1;
    check("c4_acc_we", 32'(acc_we), 32'h1);
    cyc();
    #1;
    check("c5_pc", 32'(pc), 32'h2);
    cyc();
    done = 1'b1;
    acc_write = 1'b1;
    #1;
    check("c6_acc_we", 32'(acc_we), 32'h0);
    check("c6_busy", 32'(busy), 32'h1);
    cyc();
    #1;
    check("c7_halted", 32'(halted), 32'h1);
    check("c7_busy", 32'(busy), 32'h0);
    check("c7_pc", 32'(pc), 32'h2);
`ifdef CORE_SEQUENCER_CYCLE_COUNT_EN
    check("cc_halt", cycle_count, 32'd6);
`endif

    start = 1'b1;
    cyc();
    #1;
    check("rs_latch", 32'(instr_latch), 32'h1);
    check("rs_pc", 32'(pc), 32'h0);
    check("rs_halted", 32'(halted), 32'h0);
`ifdef CORE_SEQUENCER_CYCLE_COUNT_EN
    check("cc_restart", cycle_count, 32'd0);
`endif
    cyc();
    branch = 1'b1;
    target = 10'h005;
    #1;
    check("br5_strobes", 32'({reg_we, acc_we, mem_re, mem_we}), 32'h0);
    cyc();
    #1;
    check("ld_pc", 32'(pc), 32'h5);

    cyc();
    mem_read = 1'b1;
    mem_write = 1'b1;
    reg_write = 1'b1;
    #1;
    check("ld1_mem_re", 32'(mem_re), 32'h1);
    check("ld1_gated", 32'({reg_we, acc_we, mem_we}), 32'h0);
    cyc();
    mem_read = 1'b1;
    #1;
    check("ld2_mem_re", 32'(mem_re), 32'h1);
    check("ld2_acc_we", 32'(acc_we), 32'h0);
    cyc();
    mem_read = 1'b1;
    #1;
    check("ld3_mem_re", 32'(mem_re), 32'h1);
    check("ld3_acc_we", 32'(acc_we), 32'h1);
    cyc();
    #1;
    check("ld_next_pc", 32'(pc), 32'h6);
    check("ld_next_re", 32'(mem_re), 32'h0);
    check("ld_next_latch", 32'(instr_latch), 32'h1);

    cyc();
    branch = 1'b1;
    target = 10'h010;
    cyc();
    #1;
    check("bnz_at", 32'(pc), 32'h010);
    cyc();
    branch = 1'b1;
    branch_if_zero = 1'b1;
    zero = 1'b0;
    target = 10'h040;
    cyc();
    #1;
    check("bnz_pc", 32'(pc), 32'h011);
    cyc();
    branch = 1'b1;
    target = 10'h010;
    cyc();
    #1;
    check("bz_at", 32'(pc), 32'h010);
    cyc();
    branch = 1'b1;
    branch_if_zero = 1'b1;
    zero = 1'b1;
    target = 10'h040;
    #1;
    check("bz_strobes", 32'({reg_we, acc_we, mem_re, mem_we}), 32'h0);
    cyc();
    #1;
    check("bz_pc", 32'(pc), 32'h040);

    cyc();
    branch = 1'b1;
    target = 10'h3FF;
    cyc();
    #1;
    check("wrap_at", 32'(pc), 32'h3FF);
    cyc();
    reg_write = 1'b1;
    #1;
    check("wrap_reg_we", 32'(reg_we), 32'h1);
    cyc();
    #1;
    check("wrap_pc", 32'(pc), 32'h000);
    cyc();
    cyc();
    #1;
    check("pre_rst_pc", 32'(pc), 32'h001);

    cyc();
    mem_read = 1'b1;
    start = 1'b1;
    #1;
    check("rst_exec_re", 32'(mem_re), 32'h1);
    cyc();
    mem_read = 1'b1;
    Reset = 1'b1;
    #1;
    check("rst_wait_re", 32'(mem_re), 32'h1);
    check("rst_wait_latch", 32'(instr_latch), 32'h0);
    check("rst_wait_acc", 32'(acc_we), 32'h0);
    cyc();
    Reset = 1'b0;
    #1;
    check("rst_idle_busy", 32'(busy), 32'h0);
    check("rst_idle_re", 32'(mem_re), 32'h0);
    check("rst_idle_acc", 32'(acc_we), 32'h0);
    check("rst_idle_pc", 32'(pc), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      check("rst_hold_acc", 32'(acc_we), 32'h0);
      check("rst_hold_busy", 32'(busy), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the accumulator core.
- Owns the program counter.
- Sequences instruction fetch and the decoder's control outputs into single-cycle, phase-gated write strobes.
- Stretches data-memory loads over a fixed read latency, resolves branches, and halts on the decoder's done.
- Sits between instruction ROM/decoder and the register file, accumulator and data memory.

Parameters:
PC_W, 10, program counter width; PC wraps modulo 2^PC_W
START_PC, 0, PC loaded on each accepted start
MEM_LAT, 2, data-memory read latency in cycles; legal range is >=1

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- Reset  input  1  synchronous, active-high reset
- start  input  1  begin program at START_PC; sampled only in IDLE/HALT
- mem_read  input  1  decoder: load instruction
- mem_write  input  1  decoder: store instruction
- reg_write  input  1  decoder: register-file write
- acc_write  input  1  decoder: accumulator write
- branch  input  1  decoder: branch instruction
- branch_if_zero  input  1  branch is conditional on zero
- zero  input  1  ALU zero flag
- done  input  1  decoder: halt instruction
- target  input  PC_W  absolute branch target (lookup table)
- pc  output  PC_W  instruction ROM address
- instr_latch  output  1  instruction register capture enable
- reg_we  output  1  gated register-file write
- acc_we  output  1  gated accumulator write
- mem_re  output  1  data-memory read enable
- mem_we  output  1  data-memory write enable
- busy  output  1  program executing
- halted  output  1  done reached
- cycle_count  output  32  present only with the optional feature

Behaviour:
- States: IDLE, FETCH, EXEC, MEM_WAIT, HALT.
- Reset (synchronous, active-high), from any state at the next edge:
  - state=IDLE, pc=START_PC, wait counter=0.
  - All strobes 0, busy=0, halted=0.
  - Reset overrides start.
- IDLE:
  - All outputs inactive.
  - start=1 -> FETCH, pc=START_PC.
- FETCH: one cycle.
  - instr_latch=1, busy=1.
  - Next state EXEC.
  - Decoder inputs are valid only during EXEC and MEM_WAIT.
- EXEC: one cycle, busy=1. Priority is done > mem_read > others.
  - done=1:
    - No strobes.
    - -> HALT; pc unchanged.
  - mem_read=1:
    - mem_re=1; reg_we, acc_we and mem_we are 0.
    - Wait counter loaded with MEM_LAT-1.
    - -> MEM_WAIT.
    - mem_write is ignored when mem_read is also set.
  - Otherwise:
    - reg_we=reg_write, acc_we=acc_write, mem_we=mem_write, each for exactly this cycle.
    - Branch taken = branch & (~branch_if_zero | zero).
    - pc <= taken ? target : pc+1.
    - -> FETCH.
- MEM_WAIT: exactly MEM_LAT cycles.
  - mem_re held 1, busy=1.
  - Counter decrements each cycle.
  - On the cycle the counter is 0:
    - acc_we=1.
    - pc <= pc+1.
    - -> FETCH.
  - A load is never a branch.
  - Total load time: 2+MEM_LAT cycles. Other instructions: 2 cycles.
- HALT:
  - halted=1, busy=0, strobes 0.
  - start=1 -> FETCH, pc=START_PC, halted clears at the same edge.
- start while busy: ignored.
- PC wrap: pc+1 from 2^PC_W-1 gives 0, with no flag.
- Outputs are combinational from state, counter and decoder inputs. pc is registered.

Optional Feature:
- Macro: CORE_SEQUENCER_CYCLE_COUNT_EN.
- Defined:
  - cycle_count port exists.
  - Cleared to 0 on Reset and on an accepted start.
  - Increments every cycle busy=1.
  - Saturates at 32'hFFFF_FFFF.
  - Holds in IDLE/HALT.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then start at edge 0; ROM holds ALU op (acc_write), ALU op, done:
  - pc: 0 (cycles 1–2), 1 (cycles 3–4), 2 (cycles 5–6).
  - acc_we high in cycles 2 and 4 only.
  - halted=1 from cycle 7.
  - busy low in cycle 7.
- Load at pc=5, MEM_LAT=2:
  - mem_re high for 3 consecutive cycles.
  - acc_we high only in the third of those cycles.
  - Next FETCH has pc=6.
- Conditional branch (branch_if_zero=1, target=0x040):
  - At pc=0x010 with zero=0: next pc=0x011.
  - Repeated with zero=1: next pc=0x040, no strobes.
- Non-branch ALU op at pc=0x3FF: next pc=0x000.
- Reset asserted in the first MEM_WAIT cycle:
  - Next cycle state IDLE, mem_re=0, acc_we never pulses, pc=0.
  - A start pulse during an earlier EXEC cycle has no effect.
- With CORE_SEQUENCER_CYCLE_COUNT_EN defined, program of scenario 1:
  - cycle_count=6 at halt.
  - After a second start, cycle_count reads 0 in the first FETCH cycle.
